// File: rtl/fll_boot_seq_if.sv
// Bus bundle between the peripherals' FLL request port, the boot sequencer
// and clk_rst_gen. Suffixes are from the sequencer's point of view.
interface fll_boot_seq_if;
  logic        sw_req_i;
  logic        sw_wrn_i;
  logic [1:0]  sw_add_i;
  logic [31:0] sw_wdata_i;
  logic        sw_ack_o;
  logic [31:0] sw_rdata_o;
  logic        fll_req_o;
  logic        fll_wrn_o;
  logic [1:0]  fll_add_o;
  logic [31:0] fll_wdata_o;
  logic        fll_ack_i;
  logic [31:0] fll_rdata_i;

  modport slave (
    input  sw_req_i, sw_wrn_i, sw_add_i, sw_wdata_i, fll_ack_i, fll_rdata_i,
    output sw_ack_o, sw_rdata_o, fll_req_o, fll_wrn_o, fll_add_o, fll_wdata_o
  );

  modport master (
    output sw_req_i, sw_wrn_i, sw_add_i, sw_wdata_i, fll_ack_i, fll_rdata_i,
    input  sw_ack_o, sw_rdata_o, fll_req_o, fll_wrn_o, fll_add_o, fll_wdata_o
  );
endinterface

// File: rtl/fll_boot_seq.sv
// FLL boot sequencer: two config writes, wait for lock, release fetch enable,
// then forward software accesses. Optional lock timeout: FLL_LOCK_TIMEOUT_EN.
module fll_boot_seq #(
  parameter logic [31:0] CFG1_INIT    = 32'h0000_0000,
  parameter logic [31:0] CFG2_INIT    = 32'h0000_0000,
  parameter int          LOCK_TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_enable_i,
  output logic            fetch_enable_o,
  input  logic            fll_lock_i,
  output logic            init_done_o,
  output logic            lock_timeout_o,
  fll_boot_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    BOOT, INIT1, GAP1, INIT2, WAIT_LOCK, RUN, SW_XFER
  } state_e;

  state_e      state_q;
  logic        lock_s1_q, lock_s2_q;
  logic        done_q, fe_q;
  logic        req_q, wrn_q;
  logic [1:0]  add_q;
  logic [31:0] wdata_q;

`ifdef FLL_LOCK_TIMEOUT_EN
  localparam int             CW      = $clog2(LOCK_TIMEOUT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(LOCK_TIMEOUT - 1);
  logic [CW-1:0] cnt_q;
  logic          lto_q;
`endif

  // fll_lock_i is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
    end else begin
      lock_s1_q <= fll_lock_i;
      lock_s2_q <= lock_s1_q;
    end
  end

  // Bus fields are registered together with the state so they are zero
  // whenever req is low and req always drops for a cycle between transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
      req_q   <= 1'b0;
      wrn_q   <= 1'b0;
      add_q   <= '0;
      wdata_q <= '0;
`ifdef FLL_LOCK_TIMEOUT_EN
      cnt_q   <= '0;
      lto_q   <= 1'b0;
`endif
    end else begin
      fe_q <= fetch_enable_i & done_q;
      case (state_q)
        BOOT: begin
          state_q <= INIT1;
          req_q   <= 1'b1;
          wrn_q   <= 1'b0;
          add_q   <= 2'b01;
          wdata_q <= CFG1_INIT;
        end
        INIT1: if (bus.fll_ack_i) begin
          state_q <= GAP1;
          req_q   <= 1'b0;
          add_q   <= '0;
          wdata_q <= '0;
        end
        GAP1: begin
          state_q <= INIT2;
          req_q   <= 1'b1;
          wrn_q   <= 1'b0;
          add_q   <= 2'b10;
          wdata_q <= CFG2_INIT;
        end
        INIT2: if (bus.fll_ack_i) begin
          state_q <= WAIT_LOCK;
          req_q   <= 1'b0;
          add_q   <= '0;
          wdata_q <= '0;
`ifdef FLL_LOCK_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        WAIT_LOCK: begin
          if (lock_s2_q) begin
            state_q <= RUN;
            done_q  <= 1'b1;
          end
`ifdef FLL_LOCK_TIMEOUT_EN
          else if (cnt_q == CNT_MAX) begin
            state_q <= RUN;
            done_q  <= 1'b1;
            lto_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
`endif
        end
        RUN: if (bus.sw_req_i) begin
          state_q <= SW_XFER;
          req_q   <= 1'b1;
          wrn_q   <= bus.sw_wrn_i;
          add_q   <= bus.sw_add_i;
          wdata_q <= bus.sw_wdata_i;
        end
        SW_XFER: if (bus.fll_ack_i) begin
          state_q <= RUN;
          req_q   <= 1'b0;
          wrn_q   <= 1'b0;
          add_q   <= '0;
          wdata_q <= '0;
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign bus.fll_req_o   = req_q;
  assign bus.fll_wrn_o   = wrn_q;
  assign bus.fll_add_o   = add_q;
  assign bus.fll_wdata_o = wdata_q;
  assign bus.sw_ack_o    = bus.fll_ack_i && (state_q == SW_XFER);
  assign bus.sw_rdata_o  = bus.fll_rdata_i;
  assign init_done_o     = done_q;
  assign fetch_enable_o  = fe_q;
`ifdef FLL_LOCK_TIMEOUT_EN
  assign lock_timeout_o  = lto_q;
`else
  assign lock_timeout_o  = 1'b0;
`endif

endmodule
